// File: rtl/acc_pkg.sv
// Shared constants for the partial-sum accumulator: FSM encoding, info field layout, map size.
package acc_pkg;

  localparam int unsigned MapSizeDef  = 3136;
  localparam int unsigned AddrW       = 13;
  localparam int unsigned OffW        = 12;
  localparam int unsigned InfoHalfBit = 13;
  localparam int unsigned InfoPassBit = 12;
  localparam int unsigned InfoOffMsb  = 11;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPass0 = 2'd1;
  localparam logic [1:0] StPass1 = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

endpackage

// File: rtl/psum_acc_fifo.sv
// Output FIFO for final lane sums with their buffer address; DEPTH must be a power of two.
module psum_acc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CntW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assign head_data = mem_q[rptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/psum_acc_ctrl.sv
// Two-pass partial-sum accumulator: pass 0 stores psums, pass 1 adds the stored value and emits.
// Optional PSUM_ACC_SAT_EN clamps each lane sum to the signed IN_W range.
module psum_acc_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned LANES      = 32,
  parameter int unsigned IN_W       = 20,
  parameter int unsigned MAP_SIZE   = MapSizeDef,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mac_array2psum_acc_vld,
  output logic                      mac_array2psum_acc_rdy,
  input  logic [31:0]               mac_array2psum_acc_info,
  input  logic [LANES*IN_W-1:0]     mac_array2psum_acc_data,
  output logic                      psum_wen,
  output logic [12:0]               psum_waddr,
  output logic [LANES*IN_W-1:0]     psum_wdata,
  output logic                      psum_ren,
  output logic [12:0]               psum_raddr,
  input  logic [LANES*IN_W-1:0]     psum_rdata,
  output logic                      acc2out_vld,
  input  logic                      acc2out_rdy,
  output logic [LANES*(IN_W+1)-1:0] acc2out_data,
  output logic [12:0]               acc2out_addr,
  output logic                      map_done,
  output logic                      seq_err
);

  localparam int unsigned DW     = LANES * IN_W;
  localparam int unsigned SW     = IN_W + 1;
  localparam int unsigned OW     = LANES * SW;
  localparam int unsigned FW     = OW + AddrW;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ReadyW = CntW + 1;
  localparam logic [OffW-1:0] LastOff = OffW'(MAP_SIZE - 1);

  logic             accept, beat_pass, beat_half, off_last, exp_pass;
  logic [OffW-1:0]  beat_off;
  logic [AddrW-1:0] beat_addr;
  logic             unused_info;

  assign beat_half   = mac_array2psum_acc_info[InfoHalfBit];
  assign beat_pass   = mac_array2psum_acc_info[InfoPassBit];
  assign beat_off    = mac_array2psum_acc_info[InfoOffMsb:0];
  assign beat_addr   = {beat_half, beat_off};
  assign off_last    = (beat_off == LastOff);
  assign unused_info = ^mac_array2psum_acc_info[31:14];

  logic [CntW-1:0] fifo_count;
  logic            s1_vld_q;
  logic [DW-1:0]   s1_data_q;
  logic [AddrW-1:0] s1_addr_q;

  // Stage-1 occupancy is counted so a beat in flight always has a FIFO slot reserved.
  assign mac_array2psum_acc_rdy = ({1'b0, fifo_count} + ReadyW'(s1_vld_q)) < ReadyW'(FIFO_DEPTH);
  assign accept = mac_array2psum_acc_vld && mac_array2psum_acc_rdy && !rst;

  assign psum_wen   = accept && !beat_pass;
  assign psum_ren   = accept && beat_pass;
  assign psum_waddr = beat_addr;
  assign psum_raddr = beat_addr;
  assign psum_wdata = mac_array2psum_acc_data;

  always_ff @(posedge clk) begin
    if (rst) s1_vld_q <= 1'b0;
    else     s1_vld_q <= psum_ren;
  end

  always_ff @(posedge clk) begin
    if (psum_ren) begin
      s1_data_q <= mac_array2psum_acc_data;
      s1_addr_q <= beat_addr;
    end
  end

  logic signed [SW-1:0] lane_a, lane_b, lane_s;
  logic [OW-1:0]        sum_data;

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [SW-1:0] SatMax = {2'b00, {(IN_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] SatMin = {2'b11, {(IN_W - 1){1'b0}}};
`endif

  always_comb begin
    sum_data = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_s   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = {s1_data_q[i*IN_W+IN_W-1], s1_data_q[i*IN_W +: IN_W]};
      lane_b = {psum_rdata[i*IN_W+IN_W-1], psum_rdata[i*IN_W +: IN_W]};
      lane_s = lane_a + lane_b;
`ifdef PSUM_ACC_SAT_EN
      if (lane_s > SatMax) begin
        lane_s = SatMax;
      end else if (lane_s < SatMin) begin
        lane_s = SatMin;
      end
`endif
      sum_data[i*SW +: SW] = lane_s;
    end
  end

  logic [FW-1:0] fifo_head;
  logic          fifo_pop;

  assign fifo_pop = acc2out_vld && acc2out_rdy;

  psum_acc_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_vld_q),
    .push_data ({s1_addr_q, sum_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .not_empty (acc2out_vld),
    .count     (fifo_count)
  );

  assign acc2out_addr = fifo_head[FW-1 -: AddrW];
  assign acc2out_data = fifo_head[OW-1:0];

  logic map_done_q;

  always_ff @(posedge clk) begin
    if (rst) map_done_q <= 1'b0;
    else     map_done_q <= fifo_pop && (acc2out_addr[OffW-1:0] == LastOff);
  end

  assign map_done = map_done_q;

  logic [1:0]      state_q, state_d;
  logic [OffW-1:0] exp_off_q, exp_off_d;
  logic            seq_err_q, seq_err_d;

  assign exp_pass = (state_q == StPass1);

  always_comb begin
    state_d   = state_q;
    exp_off_d = exp_off_q;
    seq_err_d = seq_err_q;
    if (accept) begin
      if ((beat_pass != exp_pass) || (beat_off != exp_off_q)) seq_err_d = 1'b1;
      // Resync to the received offset so one bad beat does not cascade into a stream of errors.
      exp_off_d = off_last ? '0 : beat_off + OffW'(1);
    end
    unique case (state_q)
      StIdle:  if (accept && !beat_pass) state_d = StPass0;
      StPass0: if (accept && off_last) state_d = StPass1;
      StPass1: if (accept && off_last) state_d = StDrain;
      StDrain: begin
        if (accept && !beat_pass) begin
          state_d = StPass0;
        end else if (!s1_vld_q && !acc2out_vld) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      exp_off_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_off_q <= exp_off_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl: behavioural buffer, arithmetic reference and scoreboard.
module tb_psum_acc_ctrl;

  localparam int LANES      = 32;
  localparam int IN_W       = 20;
  localparam int MAP_SIZE   = 3136;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = LANES * IN_W;
  localparam int SW         = IN_W + 1;
  localparam int OW         = LANES * SW;
  localparam int Bound      = 2000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mac_vld = 1'b0;
  logic           mac_rdy;
  logic [31:0]    mac_info = '0;
  logic [DW-1:0]  mac_data = '0;
  logic           psum_wen, psum_ren;
  logic [12:0]    psum_waddr, psum_raddr;
  logic [DW-1:0]  psum_wdata;
  logic [DW-1:0]  psum_rdata = '0;
  logic           acc2out_vld;
  logic           acc2out_rdy = 1'b1;
  logic [OW-1:0]  acc2out_data;
  logic [12:0]    acc2out_addr;
  logic           map_done, seq_err;

  int n_assert = 0;
  int n_fail   = 0;
  int md_cnt   = 0;
  int out_cnt  = 0;
  int prev_lane0, last_lane0;

  always #5 clk = ~clk;

  psum_acc_ctrl #(
    .LANES      (LANES),
    .IN_W       (IN_W),
    .MAP_SIZE   (MAP_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .mac_array2psum_acc_vld  (mac_vld),
    .mac_array2psum_acc_rdy  (mac_rdy),
    .mac_array2psum_acc_info (mac_info),
    .mac_array2psum_acc_data (mac_data),
    .psum_wen                (psum_wen),
    .psum_waddr              (psum_waddr),
    .psum_wdata              (psum_wdata),
    .psum_ren                (psum_ren),
    .psum_raddr              (psum_raddr),
    .psum_rdata              (psum_rdata),
    .acc2out_vld             (acc2out_vld),
    .acc2out_rdy             (acc2out_rdy),
    .acc2out_data            (acc2out_data),
    .acc2out_addr            (acc2out_addr),
    .map_done                (map_done),
    .seq_err                 (seq_err)
  );

  // Partial-sum buffer with one-cycle read latency.
  logic [DW-1:0] buf_mem [8192];
  always @(posedge clk) begin
    if (psum_wen) buf_mem[psum_waddr] <= psum_wdata;
    if (psum_ren) psum_rdata <= buf_mem[psum_raddr];
  end

  function automatic logic [OW-1:0] lane_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [OW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      s = int'($signed(a[i*IN_W +: IN_W])) + int'($signed(b[i*IN_W +: IN_W]));
`ifdef PSUM_ACC_SAT_EN
      if (s > (1 << (IN_W - 1)) - 1) s = (1 << (IN_W - 1)) - 1;
      if (s < -(1 << (IN_W - 1))) s = -(1 << (IN_W - 1));
`endif
      r[i*SW +: SW] = s[SW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v[IN_W-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    logic [31:0] t;
    for (int i = 0; i < LANES; i++) begin
      t = $urandom();
      r[i*IN_W +: IN_W] = t[IN_W-1:0];
    end
    return r;
  endfunction

  typedef struct {
    logic [12:0]   addr;
    logic [OW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_p0 [8192];

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [12:0] a;
    exp_t        e;
    if (map_done) md_cnt++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (mac_vld && mac_rdy) begin
        a = {mac_info[13], mac_info[11:0]};
        n_assert++;
        assert ((psum_wen === !mac_info[12]) && (psum_ren === mac_info[12])) else begin
          n_fail++;
          $error("FAIL strobe: wen=%b ren=%b pass=%b", psum_wen, psum_ren, mac_info[12]);
        end
        n_assert++;
        assert ((psum_waddr === a) && (psum_raddr === a)) else begin
          n_fail++;
          $error("FAIL bufaddr: waddr=%h raddr=%h expected %h", psum_waddr, psum_raddr, a);
        end
        if (!mac_info[12]) begin
          ref_p0[a] = mac_data;
        end else begin
          e.addr = a;
          e.data = lane_sum(ref_p0[a], mac_data);
          exp_q.push_back(e);
        end
      end
      if (acc2out_vld && acc2out_rdy) begin
        out_cnt++;
        prev_lane0 = last_lane0;
        last_lane0 = int'($signed(acc2out_data[SW-1:0]));
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious output: addr=%h, expected no output", acc2out_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_assert++;
          assert (acc2out_addr === e.addr) else begin
            n_fail++;
            $error("FAIL outaddr: observed %h expected %h", acc2out_addr, e.addr);
          end
          n_assert++;
          assert (acc2out_data === e.data) else begin
            n_fail++;
            $error("FAIL outdata @%h: observed %h expected %h", e.addr, acc2out_data, e.data);
          end
        end
      end
    end
  end

  task automatic chk(input int obs, input int exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic half, input logic pass, input int off, input logic [DW-1:0] d);
    int n;
    n = 0;
    mac_vld  = 1'b1;
    mac_info = {18'b0, half, pass, off[11:0]};
    mac_data = d;
    @(negedge clk);
    while (!mac_rdy && n < Bound) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    assert (n < Bound) else begin
      n_fail++;
      $error("FAIL accept timeout: waited %0d cycles, limit %0d", n, Bound);
    end
    step();
    mac_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || acc2out_vld) && n < Bound) begin
      step();
      n++;
    end
    n_assert++;
    assert (n < Bound) else begin
      n_fail++;
      $error("FAIL drain timeout: %0d entries still pending, expected 0", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    mac_vld = 1'b0;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int md_base;
    logic bp_done;

    // Reset state
    step();
    rst = 1'b0;
    @(negedge clk);
    chk(mac_rdy, 1, "reset rdy");
    chk(acc2out_vld, 0, "reset acc2out_vld");
    chk(map_done, 0, "reset map_done");
    chk(seq_err, 0, "reset seq_err");
    chk(psum_wen | psum_ren, 0, "reset strobes");
    step();

    // Nominal map: +5 then +7, with first-word latency check
    for (int o = 0; o < MAP_SIZE; o++) send(1'b0, 1'b0, o, fill(5));
    send(1'b0, 1'b1, 0, fill(7));
    @(negedge clk);
    chk(acc2out_vld, 0, "latency cycle1 vld");
    step();
    @(negedge clk);
    chk(acc2out_vld, 1, "latency cycle2 vld");
    chk(acc2out_addr, 0, "latency first addr");
    step();
    for (int o = 1; o < MAP_SIZE; o++) send(1'b0, 1'b1, o, fill(7));
    wait_drain();
    chk(out_cnt, MAP_SIZE, "nominal outputs");
    chk(last_lane0, 12, "nominal lane0 value");
    chk(md_cnt, 1, "nominal map_done");
    chk(seq_err, 0, "nominal seq_err");

    // Backpressure with random data on the upper half of the buffer
    for (int o = 0; o < MAP_SIZE; o++) send(1'b1, 1'b0, o, rand_data());
    acc2out_rdy = 1'b0;
    base = out_cnt;
    for (int o = 0; o < FIFO_DEPTH; o++) send(1'b1, 1'b1, o, rand_data());
    @(negedge clk);
    chk(mac_rdy, 0, "bp rdy low");
    step();
    @(negedge clk);
    chk(mac_rdy, 0, "bp rdy held");
    chk(out_cnt, base, "bp no output while stalled");
    step();
    bp_done = 1'b0;
    fork
      begin
        for (int o = FIFO_DEPTH; o < MAP_SIZE; o++) send(1'b1, 1'b1, o, rand_data());
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          acc2out_rdy = 1'($urandom_range(0, 1));
          step();
        end
        acc2out_rdy = 1'b1;
      end
    join
    wait_drain();
    chk(out_cnt, 2 * MAP_SIZE, "bp outputs");
    chk(md_cnt, 2, "bp map_done");
    chk(seq_err, 0, "bp seq_err");

    // Lane-sum extremes
    do_reset();
    send(1'b0, 1'b0, 0, fill(524287));
    send(1'b0, 1'b0, 1, fill(-524288));
    send(1'b0, 1'b1, 0, fill(524287));
    send(1'b0, 1'b1, 1, fill(-524288));
    wait_drain();
`ifdef PSUM_ACC_SAT_EN
    chk(prev_lane0, 524287, "overflow positive");
    chk(last_lane0, -524288, "overflow negative");
`else
    chk(prev_lane0, 1048574, "overflow positive");
    chk(last_lane0, -1048576, "overflow negative");
`endif

    // Sequencing errors
    do_reset();
    @(negedge clk);
    chk(seq_err, 0, "seq after reset");
    step();
    send(1'b0, 1'b1, 0, fill(1));
    @(negedge clk);
    chk(seq_err, 1, "seq pass1 from idle");
    step();
    send(1'b0, 1'b0, 0, fill(1));
    send(1'b0, 1'b0, 1, fill(1));
    @(negedge clk);
    chk(seq_err, 1, "seq sticky");
    step();
    wait_drain();
    do_reset();
    for (int o = 0; o < 7; o++) send(1'b0, 1'b0, o, fill(o));
    @(negedge clk);
    chk(seq_err, 0, "seq in order");
    step();
    send(1'b0, 1'b0, 9, fill(9));
    @(negedge clk);
    chk(seq_err, 1, "seq offset skip");
    step();

    // Reset mid-way through pass 1
    do_reset();
    for (int o = 0; o < MAP_SIZE; o++) send(1'b0, 1'b0, o, rand_data());
    for (int o = 0; o <= 1000; o++) send(1'b0, 1'b1, o, rand_data());
    md_base = md_cnt;
    do_reset();
    base = out_cnt;
    @(negedge clk);
    chk(acc2out_vld, 0, "midreset acc2out_vld");
    chk(map_done, 0, "midreset map_done");
    chk(mac_rdy, 1, "midreset rdy");
    step();
    send(1'b0, 1'b0, 0, fill(3));
    repeat (4) step();
    @(negedge clk);
    chk(seq_err, 0, "midreset back to idle");
    chk(out_cnt, base, "midreset no stale output");
    chk(md_cnt, md_base, "midreset no map_done");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_acc_ctrl.md
PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 SHALL expose parameter LANES, default 32: parallel output-channel lanes per beat.
REQ-002 SHALL expose parameter IN_W, default 20: signed partial-sum width per lane.
REQ-003 SHALL expose parameter MAP_SIZE, default 3136: pixels per 56x56 output map.
REQ-004 SHALL expose parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mac_array2psum_acc_vld  in  1  beat valid
- mac_array2psum_acc_rdy  out  1  beat accepted when vld&&rdy
- mac_array2psum_acc_info  in  32  [13] out-ch half, [12] pass (0: first in-ch group, 1: second), [11:0] pixel offset; [31:14] ignored
- mac_array2psum_acc_data  in  LANES*IN_W  packed signed psums
- psum_wen  out  1  buffer write strobe
- psum_waddr  out  13  {half, offset}
- psum_wdata  out  LANES*IN_W  buffer write data
- psum_ren  out  1  buffer read strobe
- psum_raddr  out  13  {half, offset}
- psum_rdata  in  LANES*IN_W  read data, valid exactly 1 cycle after psum_ren
- acc2out_vld  out  1  final sum valid
- acc2out_rdy  in  1  downstream ready
- acc2out_data  out  LANES*(IN_W+1)  final signed sums
- acc2out_addr  out  13  {half, offset}
- map_done  out  1  1-cycle pulse
- seq_err  out  1  sticky sequence error

Function
REQ-007 SHALL write a pass-0 beat to the buffer on the acceptance cycle: psum_wen=1, waddr={info[13],info[11:0]}, wdata=data.
REQ-008 SHALL, for a pass-1 beat, assert psum_ren with the same address on the acceptance cycle, hold the beat in stage-1 one cycle, then add per lane (sign-extended to IN_W+1) and push sum plus address into the output FIFO.
REQ-009 SHALL never write and read the buffer in the same cycle; pass-0 and pass-1 beats are never interleaved.
REQ-010 SHALL drive rdy = (fifo_count + stage1_valid) < FIFO_DEPTH, combinationally from registered state only (no dependence on vld).
REQ-011 SHALL present the FIFO head on acc2out_*; first-word latency from pass-1 acceptance to acc2out_vld is 2 cycles; sustained throughput 1 beat/cycle while acc2out_rdy=1.
REQ-012 SHALL let a simultaneous FIFO push and pop leave fifo_count unchanged.
REQ-013 SHALL run an FSM: IDLE -> PASS0 on the first accepted beat with pass=0; PASS0 -> PASS1 after offset MAP_SIZE-1 is accepted; PASS1 -> DRAIN after offset MAP_SIZE-1 is accepted; DRAIN -> IDLE once the FIFO is empty and stage-1 is idle.
REQ-014 SHALL track an expected offset counter that wraps MAP_SIZE-1 -> 0 at each pass boundary.
REQ-015 SHALL set seq_err on any accepted beat whose pass bit or offset disagrees with the FSM state or counter; the beat is still processed and seq_err stays set until reset.
REQ-016 SHALL pulse map_done for one cycle when a FIFO entry with offset MAP_SIZE-1 is popped (vld&&rdy).
REQ-017 SHALL accept beats in DRAIN; a pass-0 beat in DRAIN starts the next map in PASS0.

Reset
REQ-018 SHALL reset FSM to IDLE and clear counters, FIFO pointers, stage-1 valid, acc2out_vld, psum_wen, psum_ren, map_done and seq_err; rdy is 1 in the cycle after reset deasserts.
REQ-019 SHALL discard in-flight beats and buffered sums on reset mid-operation, without emitting map_done.

Configuration
REQ-020 SHALL, when PSUM_ACC_SAT_EN is defined, clamp each lane sum to the signed IN_W range [-2^(IN_W-1), 2^(IN_W-1)-1] before sign-extending it to IN_W+1.
REQ-021 SHALL, without PSUM_ACC_SAT_EN, output the full IN_W+1 sum, which is exact and cannot overflow.

Structure
REQ-022 SHALL place the FSM state encoding, info bit-field positions and MAP_SIZE default in shared package acc_pkg.
REQ-023 SHALL implement the output FIFO as sub-module psum_acc_fifo.

Verification
REQ-024 SHALL test a nominal map: 3136 pass-0 beats of +5, then 3136 pass-1 beats of +7 with acc2out_rdy=1 -> 3136 outputs of 12 in offset order, one map_done, seq_err=0.
REQ-025 SHALL test backpressure: acc2out_rdy=0 during pass 1 -> rdy drops after FIFO_DEPTH accepted beats; releasing rdy delivers them with none lost or duplicated.
REQ-026 SHALL test overflow with IN_W=20, both passes 524287 -> output 1048574 without the macro, 524287 with PSUM_ACC_SAT_EN; both passes -524288 -> -1048576 / -524288.
REQ-027 SHALL test sequencing: a pass-1 beat at offset 0 from IDLE -> seq_err=1 and sticky; offset 7 expected, 9 sent -> seq_err=1.
REQ-028 SHALL test reset at pass-1 offset 1000 -> next cycle acc2out_vld=0, FSM IDLE, no map_done.
REQ-029 SHALL test the half bit: run info[13]=1 -> all psum_waddr/raddr[12]=1 and acc2out_addr[12]=1.
